axis_route_commit: RTL

AXIS_ROUTE_COMMIT -- requirements
Module: axis_route_commit

---
 rtl/axis_route_commit_if.sv | 15 +
 rtl/axis_route_commit.sv | 56 +++++
 2 files changed

// File: rtl/axis_route_commit_if.sv
// axis_route_commit_if: per-lane AXI-Stream bundle with N_ID lanes packed side by side.
interface axis_route_commit_if #(
   parameter int N_ID      = 4,
   parameter int DATA_BITS = 64,
   parameter int ID_BITS   = 6
);
   logic [N_ID-1:0]                  tvalid;
   logic [N_ID-1:0]                  tready;
   logic [N_ID-1:0]                  tlast;
   logic [N_ID-1:0][DATA_BITS-1:0]   tdata;
   logic [N_ID-1:0][DATA_BITS/8-1:0] tkeep;
   logic [N_ID-1:0][ID_BITS-1:0]     tid;
   modport master (output tvalid, tdata, tkeep, tlast, tid, input tready);
   modport slave (input tvalid, tdata, tkeep, tlast, tid, output tready);
endinterface

// File: rtl/axis_route_commit.sv
// axis_route_commit: per-lane route update that commits only between packets, with a one-cycle stream bubble.
module axis_route_commit #(
   parameter int         N_ID      = 4,
   parameter int         DATA_BITS = 64,
   parameter int         ID_BITS   = 6,
   parameter logic [7:0] ROUTE_RST = 8'h00
) (
   input  logic                 aclk,
   input  logic                 areset,
   input  logic [N_ID-1:0]      route_req_valid,
   input  logic [N_ID-1:0][7:0] route_req_data,
   output logic [N_ID-1:0]      route_req_ready,
   output logic [N_ID-1:0][7:0] route_out,
   output logic [N_ID-1:0]      route_pend,
   output logic [N_ID-1:0]      pkt_active,
   axis_route_commit_if.slave   s,
   axis_route_commit_if.master  m
);
   logic [N_ID-1:0]      pend_q, in_pkt, hold, gate, beat;
   logic [N_ID-1:0][7:0] route_q, pend_route;
   // hold only opens between packets, so route_q is stable across every packet
   always_comb begin
      hold            = pend_q & ~in_pkt;
      gate            = hold | {N_ID{areset}};
      beat            = s.tvalid & m.tready & ~gate;
      route_req_ready = ~pend_q & ~{N_ID{areset}};
      m.tvalid        = s.tvalid & ~gate;
      s.tready        = m.tready & ~gate;
   end
   for (genvar j = 0; j < N_ID; j++) begin : g_lane
      assign m.tdata[j] = s.tdata[j][DATA_BITS-1:0];
      assign m.tkeep[j] = s.tkeep[j][DATA_BITS/8-1:0];
      assign m.tid[j]   = s.tid[j][ID_BITS-1:0];
      assign m.tlast[j] = s.tlast[j];
   end
   always_ff @(posedge aclk)
      if (areset) begin
         route_q    <= {N_ID{ROUTE_RST}};
         pend_q     <= '0;
         in_pkt     <= '0;
         pend_route <= '0;
      end else
         for (int i = 0; i < N_ID; i++) begin
            if (hold[i]) begin
               route_q[i] <= pend_route[i];
               pend_q[i]  <= 1'b0;
            end else if (route_req_valid[i] && route_req_ready[i]) begin
               pend_q[i]     <= 1'b1;
               pend_route[i] <= route_req_data[i];
            end
            if (beat[i]) in_pkt[i] <= !s.tlast[i];
         end
   assign route_out  = route_q;
   assign route_pend = pend_q;
   assign pkt_active = in_pkt;
endmodule
